// File: rtl/multdiv_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring) unit, one bit per clock.
// Define MULTDIV_DIV_EN to compile in the divide state and datapath; otherwise ctrl_DIV is ignored.
module multdiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int unsigned CW = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
`ifdef MULTDIV_DIV_EN
        S_DIV  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             qm1_q, qm1_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;
    logic             busy_q, busy_d;

    // Booth step: 33-bit add/subtract so M = most-negative value cannot overflow the accumulator
    logic [WIDTH:0] acc_ext, m_ext, booth_sum;
    logic           mul_ovf;

    assign acc_ext = {acc_q[WIDTH-1], acc_q};
    assign m_ext   = {m_q[WIDTH-1], m_q};

    always_comb begin
        booth_sum = acc_ext;
        unique case ({q_q[0], qm1_q})
            2'b01:   booth_sum = acc_ext + m_ext;
            2'b10:   booth_sum = acc_ext - m_ext;
            default: booth_sum = acc_ext;
        endcase
    end

    // Product bits [2W-1:W-1] must all match for the low word to be a valid signed result
    assign mul_ovf = ~((&{acc_q, q_q[WIDTH-1]}) | ~(|{acc_q, q_q[WIDTH-1]}));

`ifdef MULTDIV_DIV_EN
    logic             neg_q, neg_d;
    logic             dz_q, dz_d;
    logic [WIDTH:0]   div_shift, div_diff;
    logic [WIDTH-1:0] abs_a, abs_b, quo_signed;

    assign abs_a      = data_operandA[WIDTH-1] ? WIDTH'(0) - data_operandA : data_operandA;
    assign abs_b      = data_operandB[WIDTH-1] ? WIDTH'(0) - data_operandB : data_operandB;
    assign div_shift  = {acc_q, q_q[WIDTH-1]};
    assign div_diff   = div_shift - {1'b0, m_q};
    assign quo_signed = neg_q ? WIDTH'(0) - q_q : q_q;
`else
    logic unused_ctrl_div;
    assign unused_ctrl_div = ctrl_DIV;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        q_d      = q_q;
        qm1_d    = qm1_q;
        m_d      = m_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;
`ifdef MULTDIV_DIV_EN
        neg_d    = neg_q;
        dz_d     = dz_q;
`endif
        if (ctrl_MULT) begin
            state_d = S_MULT;
            cnt_d   = CW'(WIDTH);
            acc_d   = '0;
            q_d     = data_operandB;
            qm1_d   = 1'b0;
            m_d     = data_operandA;
        end
`ifdef MULTDIV_DIV_EN
        else if (ctrl_DIV) begin
            state_d = S_DIV;
            cnt_d   = CW'(WIDTH);
            acc_d   = '0;
            q_d     = abs_a;
            qm1_d   = 1'b0;
            m_d     = abs_b;
            neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            dz_d    = (data_operandB == '0);
        end
`endif
        else begin
            unique case (state_q)
                S_MULT: begin
                    if (cnt_q == '0) begin
                        state_d  = S_DONE;
                        result_d = q_q;
                        exc_d    = mul_ovf;
                        rdy_d    = 1'b1;
                    end else begin
                        acc_d = booth_sum[WIDTH:1];
                        q_d   = {booth_sum[0], q_q[WIDTH-1:1]};
                        qm1_d = q_q[0];
                        cnt_d = cnt_q - CW'(1);
                    end
                end
`ifdef MULTDIV_DIV_EN
                S_DIV: begin
                    if (cnt_q == '0) begin
                        state_d  = S_DONE;
                        result_d = dz_q ? '0 : quo_signed;
                        exc_d    = dz_q | (~neg_q & q_q[WIDTH-1]);
                        rdy_d    = 1'b1;
                    end else begin
                        if (!div_diff[WIDTH]) begin
                            acc_d = div_diff[WIDTH-1:0];
                            q_d   = {q_q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_d = div_shift[WIDTH-1:0];
                            q_d   = {q_q[WIDTH-2:0], 1'b0};
                        end
                        cnt_d = cnt_q - CW'(1);
                    end
                end
`endif
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            q_q      <= '0;
            qm1_q    <= 1'b0;
            m_q      <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
`ifdef MULTDIV_DIV_EN
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            q_q      <= q_d;
            qm1_q    <= qm1_d;
            m_q      <= m_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
`ifdef MULTDIV_DIV_EN
            neg_q    <= neg_d;
            dz_q     <= dz_d;
`endif
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed corner cases plus a random back-to-back chain
// checked against a plain-arithmetic reference model.
module tb_multdiv_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int checks = 0;
    int errors = 0;

    multdiv_unit #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    // Reference: {exception, result} from plain signed arithmetic
    function automatic logic [32:0] model(input logic is_mul, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        logic signed [31:0] q;
        if (is_mul) begin
            p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            return {(p != {{32{p[31]}}, p[31:0]}), p[31:0]};
        end
        if (b == 32'd0) return {1'b1, 32'h0};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        return {1'b0, q};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a start strobe for one edge; returns at the negedge after the start edge
    task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Count edges until RDY (bounded) while scrambling operands; also count busy cycles
    task automatic wait_rdy(output int n, output int nb);
        n  = 0;
        nb = 0;
        while (1) begin
            if (busy) nb++;
            if (data_resultRDY || n >= 100) break;
            @(negedge clock);
            n++;
            data_operandA = $urandom;
            data_operandB = $urandom;
        end
    endtask

    task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        logic [32:0] e;
        int n, nb;
        e = model(m, a, b);
        start_op(m, d, a, b);
        wait_rdy(n, nb);
        check({tag, "_lat"}, 32'(n), 32'd33);
        check({tag, "_busy"}, 32'(nb), 32'd34);
        check({tag, "_res"}, data_result, e[31:0]);
        check({tag, "_exc"}, 32'(data_exception), 32'(e[32]));
    endtask

    task automatic idle_check(input string tag, input logic [31:0] held);
        @(negedge clock);
        check({tag, "_rdy_fall"}, 32'(data_resultRDY), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_hold"}, data_result, held);
    endtask

    task automatic quiet_check(input string tag, input int cycles);
        int stray;
        stray = 0;
        repeat (cycles) begin
            @(negedge clock);
            if (data_resultRDY || busy) stray++;
        end
        check({tag, "_quiet"}, 32'(stray), 32'd0);
    endtask

    initial begin
        int n, nb, stray;
        logic        m;
        logic [31:0] a, b;

        reset_n       = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(negedge clock);
        check("rst_res", data_result, 32'h0);
        check("rst_exc", 32'(data_exception), 32'd0);
        check("rst_rdy", 32'(data_resultRDY), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, "mul_basic");
        check("mul_basic_const", data_result, 32'hFFFF_FFEB);
        idle_check("mul_basic", 32'hFFFF_FFEB);
        run_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, "mul_ovf");
        idle_check("mul_ovf", 32'h0);
        run_op(1'b1, 1'b0, 32'h8000_0000, 32'd1, "mul_min");
        idle_check("mul_min", 32'h8000_0000);

`ifdef MULTDIV_DIV_EN
        run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, "div_neg");
        idle_check("div_neg", 32'hFFFF_FFFD);
        run_op(1'b0, 1'b1, 32'd100, 32'd7, "div_pos");
        run_op(1'b0, 1'b1, 32'd5, 32'd0, "div_zero");
        run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        idle_check("div_ovf", 32'h8000_0000);
`else
        // ctrl_DIV alone must be a no-op
        ctrl_DIV = 1'b1;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        check("nodiv_busy", 32'(busy), 32'd0);
        quiet_check("nodiv", 40);
        // ctrl_DIV during a multiply must not abort it
        start_op(1'b1, 1'b0, 32'd9, 32'd9);
        repeat (5) @(negedge clock);
        ctrl_DIV = 1'b1;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        wait_rdy(n, nb);
        check("nodiv_mid_lat", 32'(n + 6), 32'd33);
        check("nodiv_mid_res", data_result, 32'd81);
        idle_check("nodiv_mid", 32'd81);
`endif

        // Restart: a second start at cycle 10 aborts the first with no RDY
        a = data_result;
        start_op(1'b1, 1'b0, 32'd3, 32'd4);
        check("restart_hold", data_result, a);
        stray = 0;
        repeat (9) begin
            @(negedge clock);
            if (data_resultRDY) stray++;
        end
        check("restart_no_rdy", 32'(stray), 32'd0);
`ifdef MULTDIV_DIV_EN
        run_op(1'b0, 1'b1, 32'd100, 32'd7, "restart");
        check("restart_const", data_result, 32'd14);
`else
        run_op(1'b1, 1'b0, 32'd100, 32'd7, "restart");
        check("restart_const", data_result, 32'd700);
`endif
        quiet_check("restart", 40);

        run_op(1'b1, 1'b1, 32'd6, 32'd2, "both");
        check("both_const", data_result, 32'd12);
        idle_check("both", 32'd12);

        // Asynchronous reset mid-multiply
        start_op(1'b1, 1'b0, 32'h0001_2345, 32'h0000_0777);
        repeat (14) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("arst_res", data_result, 32'h0);
        check("arst_exc", 32'(data_exception), 32'd0);
        check("arst_rdy", 32'(data_resultRDY), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        quiet_check("arst", 50);

        // Random back-to-back chain: each start lands in the previous RDY cycle
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 2 == 0) begin
                a = 32'($urandom_range(0, 4000)) - 32'd2000;
                b = 32'($urandom_range(0, 400)) - 32'd200;
            end
            if (i == 7) b = 32'd0;
`ifdef MULTDIV_DIV_EN
            m = 1'($urandom_range(0, 1));
`else
            m = 1'b1;
`endif
            run_op(m, ~m, a, b, "b2b");
        end
        idle_check("b2b_end", data_result);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
